// File: rtl/game_pkg.sv
// Shared types and constants for the score tracker: FSM state encoding,
// player identifiers, winner codes and default sizing.
package game_pkg;

   localparam int DEF_SCORE_W   = 4;
   localparam int DEF_WIN_SCORE = 10;

   // Match FSM encoding; code 2'b11 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      DONE = 2'b10
   } state_t;

   // Identifies which player earned the most recent single-player point.
   typedef enum logic {
      P1 = 1'b0,
      P2 = 1'b1
   } player_t;

   localparam logic [1:0] WINNER_NONE = 2'b00;
   localparam logic [1:0] WINNER_P1   = 2'b01;
   localparam logic [1:0] WINNER_P2   = 2'b10;
   localparam logic [1:0] WINNER_TIE  = 2'b11;

   // Maps "player 1 reached the target" / "player 2 reached the target"
   // onto the winner output code.
   function automatic logic [1:0] winner_code(input logic p1_won, input logic p2_won);
      logic [1:0] code;
      code = WINNER_NONE;
      if (p1_won && p2_won) begin
         code = WINNER_TIE;
      end else if (p1_won) begin
         code = WINNER_P1;
      end else if (p2_won) begin
         code = WINNER_P2;
      end
      return code;
   endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Bundle of the game-FSM facing signals of the score tracker.
// The master side is the game FSM (or a testbench); the slave side is the tracker.
interface score_tracker_if
   import game_pkg::*;
#(
   parameter int SCORE_W = DEF_SCORE_W
);

   logic               start;
   logic [1:0]         sum;
   logic [2:0]         boison;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic               finish;
   logic [1:0]         winner;
   logic [1:0]         state;

   modport master (
      output start,
      output sum,
      output boison,
      input  score1,
      input  score2,
      input  finish,
      input  winner,
      input  state
   );

   modport slave (
      input  start,
      input  sum,
      input  boison,
      output score1,
      output score2,
      output finish,
      output winner,
      output state
   );

endinterface

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector: a bit rises when it is 1 now and was 0 at
// the previous clock edge. History clears on synchronous reset, so a level
// already high when reset releases counts as a fresh rise.
module rise_detect #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] history;

   // Remember the input level sampled at each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         history <= '0;
      end else begin
         history <= din;
      end
   end

   assign rise = din & ~history;

endmodule

// File: rtl/score_tracker.sv
// Two-player score tracker. Point requests arrive as levels on sum; only
// their rising edges count. A bonus (nonzero boison after zero) goes to the
// most recent single scorer. Scores saturate at WIN_SCORE, which ends the match.
module score_tracker
   import game_pkg::*;
#(
   parameter int SCORE_W   = DEF_SCORE_W,
   parameter int WIN_SCORE = DEF_WIN_SCORE
) (
   input  logic           clk,
   input  logic           rst,
   score_tracker_if.slave bus
);

   // Three spare bits cover a point (1) plus the largest bonus (7) on top of any score.
   localparam int SUM_W = SCORE_W + 3;
   localparam logic [SUM_W-1:0]   WIN_WIDE   = SUM_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] WIN_NARROW = SCORE_W'(WIN_SCORE);

   state_t             state_q,  state_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic               finish_q, finish_d;
   logic [1:0]         winner_q, winner_d;
   player_t            last_q,   last_d;

   logic [1:0]         sum_rise;
   logic               boison_nz;
   logic               bonus_rise;

   logic [SUM_W-1:0]   bonus_val;
   logic [SUM_W-1:0]   add1;
   logic [SUM_W-1:0]   add2;
   logic [SUM_W-1:0]   wide1;
   logic [SUM_W-1:0]   wide2;
   logic [SCORE_W-1:0] sat1;
   logic [SCORE_W-1:0] sat2;
   logic               reach1;
   logic               reach2;

   rise_detect #(.WIDTH(2)) u_sum_rise (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.sum),
      .rise (sum_rise)
   );

   assign boison_nz = |bus.boison;

   rise_detect #(.WIDTH(1)) u_bonus_rise (
      .clk  (clk),
      .rst  (rst),
      .din  (boison_nz),
      .rise (bonus_rise)
   );

   // Work out the candidate scores for this cycle and the next FSM state.
   always_comb begin
      state_d  = state_q;
      score1_d = score1_q;
      score2_d = score2_q;
      finish_d = finish_q;
      winner_d = winner_q;
      last_d   = last_q;

      bonus_val = bonus_rise ? SUM_W'(bus.boison) : '0;
      add1      = SUM_W'(sum_rise[0]);
      add2      = SUM_W'(sum_rise[1]);

      if (sum_rise == 2'b01) begin
         add1 = add1 + bonus_val;
      end else if (sum_rise == 2'b10) begin
         add2 = add2 + bonus_val;
      end else if (sum_rise == 2'b00) begin
         if (last_q == P1) begin
            add1 = bonus_val;
         end else begin
            add2 = bonus_val;
         end
      end

      wide1  = {3'b000, score1_q} + add1;
      wide2  = {3'b000, score2_q} + add2;
      sat1   = (wide1 >= WIN_WIDE) ? WIN_NARROW : wide1[SCORE_W-1:0];
      sat2   = (wide2 >= WIN_WIDE) ? WIN_NARROW : wide2[SCORE_W-1:0];
      reach1 = (sat1 == WIN_NARROW);
      reach2 = (sat2 == WIN_NARROW);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = PLAY;
               score1_d = '0;
               score2_d = '0;
               finish_d = 1'b0;
               winner_d = WINNER_NONE;
            end
         end
         PLAY: begin
            if (bus.start) begin
               score1_d = '0;
               score2_d = '0;
               finish_d = 1'b0;
               winner_d = WINNER_NONE;
            end else begin
               score1_d = sat1;
               score2_d = sat2;
               if (sum_rise == 2'b01) begin
                  last_d = P1;
               end else if (sum_rise == 2'b10) begin
                  last_d = P2;
               end
               if (reach1 || reach2) begin
                  state_d  = DONE;
                  finish_d = 1'b1;
                  winner_d = winner_code(reach1, reach2);
               end
            end
         end
         DONE: begin
            if (bus.start) begin
               state_d  = PLAY;
               score1_d = '0;
               score2_d = '0;
               finish_d = 1'b0;
               winner_d = WINNER_NONE;
            end
         end
         default: begin
            state_d  = IDLE;
            score1_d = '0;
            score2_d = '0;
            finish_d = 1'b0;
            winner_d = WINNER_NONE;
         end
      endcase
   end

   // All tracker registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         score1_q <= '0;
         score2_q <= '0;
         finish_q <= 1'b0;
         winner_q <= WINNER_NONE;
         last_q   <= P1;
      end else begin
         state_q  <= state_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         finish_q <= finish_d;
         winner_q <= winner_d;
         last_q   <= last_d;
      end
   end

   assign bus.score1 = score1_q;
   assign bus.score2 = score2_q;
   assign bus.finish = finish_q;
   assign bus.winner = winner_q;
   assign bus.state  = state_q;

endmodule
